// File: rtl/multi_interval_timer.sv
// Multi-channel Avalon-MM interval timer: NUM_CH independent down-counters, each with
// a prescaler, snapshot register, missed-timeout detection and its own interrupt line.
module multi_interval_timer #(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned RESET_PERIOD = 49999,
   localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CH_W+2:0]   address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [NUM_CH-1:0] irq_vec,
   output logic              irq
);

   localparam int unsigned PSC_W = 16;
   localparam int unsigned DATA_W = 32;

   localparam logic [2:0] REG_STATUS   = 3'd0;
   localparam logic [2:0] REG_CONTROL  = 3'd1;
   localparam logic [2:0] REG_PERIOD   = 3'd2;
   localparam logic [2:0] REG_SNAP     = 3'd3;
   localparam logic [2:0] REG_PRESCALE = 3'd4;

   logic [CH_W-1:0]               ch_sel;
   logic [2:0]                    reg_sel;
   logic                          ch_ok_c;
   logic                          wr_en_c;
   logic [NUM_CH-1:0][DATA_W-1:0] ch_rdata;
   logic [DATA_W-1:0]             rd_c;
   logic [DATA_W-1:0]             rdata_q;

   assign ch_sel  = address[CH_W+2:3];
   assign reg_sel = address[2:0];

   // Channel indices that exist; the select field may encode more than NUM_CH
   always_comb begin
      ch_ok_c = 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (ch_sel == CH_W'(k)) ch_ok_c = 1'b1;
      end
   end

   assign wr_en_c = chipselect & ~write_n & ch_ok_c & (reg_sel <= REG_PRESCALE);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic [CNT_W-1:0]  period_q, period_d;
      logic [CNT_W-1:0]  snap_q, snap_d;
      logic [PSC_W-1:0]  psc_q, psc_d;
      logic [PSC_W-1:0]  pc_q, pc_d;
      logic              run_q, run_d;
      logic              to_q, to_d;
      logic              missed_q, missed_d;
      logic              cont_q, cont_d;
      logic              ito_q, ito_d;
      logic              reload_q, reload_d;
      logic              sel_c;
      logic              clr_c;
      logic              timeout_c;
      logic [DATA_W-1:0] rdata_c;

      assign sel_c = wr_en_c && (ch_sel == CH_W'(i));
      assign clr_c = sel_c && (reg_sel == REG_STATUS);

      always_comb begin
         cnt_d     = cnt_q;
         period_d  = period_q;
         snap_d    = snap_q;
         psc_d     = psc_q;
         pc_d      = pc_q;
         run_d     = run_q;
         cont_d    = cont_q;
         ito_d     = ito_q;
         reload_d  = 1'b0;
         timeout_c = 1'b0;

         // A pending reload after a PERIOD/PRESCALE write outranks both the tick and START
         if (reload_q) begin
            cnt_d = period_q;
            pc_d  = psc_q;
            run_d = 1'b0;
         end else begin
            if (run_q) begin
               if (pc_q == '0) begin
                  pc_d = psc_q;
                  if (cnt_q == '0) begin
                     cnt_d     = period_q;
                     timeout_c = 1'b1;
                     if (!cont_q) run_d = 1'b0;
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end else begin
                  pc_d = pc_q - PSC_W'(1);
               end
            end
            if (sel_c && (reg_sel == REG_CONTROL)) begin
               if (writedata[2])      run_d = 1'b1;
               else if (writedata[3]) run_d = 1'b0;
            end
         end

         if (sel_c) begin
            case (reg_sel)
               REG_CONTROL: begin
                  cont_d = writedata[1];
                  ito_d  = writedata[0];
               end
               REG_PERIOD: begin
                  period_d = writedata[CNT_W-1:0];
                  reload_d = 1'b1;
               end
               REG_SNAP:   snap_d = cnt_q;
               REG_PRESCALE: begin
                  psc_d    = writedata[PSC_W-1:0];
                  reload_d = 1'b1;
               end
               default: ;
            endcase
         end

         // A timeout in the same cycle as a STATUS clear still leaves TO set
         to_d     = timeout_c | (to_q & ~clr_c);
         missed_d = ~clr_c & (missed_q | (timeout_c & to_q));
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q    <= CNT_W'(RESET_PERIOD);
            period_q <= CNT_W'(RESET_PERIOD);
            snap_q   <= '0;
            psc_q    <= '0;
            pc_q     <= '0;
            run_q    <= 1'b0;
            to_q     <= 1'b0;
            missed_q <= 1'b0;
            cont_q   <= 1'b0;
            ito_q    <= 1'b0;
            reload_q <= 1'b0;
         end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            snap_q   <= snap_d;
            psc_q    <= psc_d;
            pc_q     <= pc_d;
            run_q    <= run_d;
            to_q     <= to_d;
            missed_q <= missed_d;
            cont_q   <= cont_d;
            ito_q    <= ito_d;
            reload_q <= reload_d;
         end
      end

      always_comb begin
         rdata_c = '0;
         case (reg_sel)
            REG_STATUS:   rdata_c = {29'd0, missed_q, run_q, to_q};
            REG_CONTROL:  rdata_c = {30'd0, cont_q, ito_q};
            REG_PERIOD:   rdata_c = DATA_W'(period_q);
            REG_SNAP:     rdata_c = DATA_W'(snap_q);
            REG_PRESCALE: rdata_c = DATA_W'(psc_q);
            default:      rdata_c = '0;
         endcase
      end

      assign ch_rdata[i] = rdata_c;
      assign irq_vec[i]  = to_q & ito_q;
   end

   // Read data follows the address every cycle, independent of chipselect
   always_comb begin
      rd_c = '0;
      if (ch_ok_c) rd_c = ch_rdata[ch_sel];
   end

   always_ff @(posedge clk) begin
      if (reset) rdata_q <= '0;
      else       rdata_q <= rd_c;
   end

   assign readdata = rdata_q;
   assign irq      = |irq_vec;

endmodule

// File: tb/tb_multi_interval_timer.sv
// Randomised bench for multi_interval_timer against a cycle-level reference model,
// plus directed scenarios for the headline timer behaviours.
module tb_multi_interval_timer;

   localparam int unsigned NUM_CH       = 4;
   localparam int unsigned CNT_W        = 32;
   localparam int unsigned CH_W         = 2;
   localparam int unsigned RESET_PERIOD = 49999;

   logic              clk = 1'b0;
   logic              reset;
   logic [CH_W+2:0]   address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic [NUM_CH-1:0] irq_vec;
   logic              irq;

   multi_interval_timer #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .RESET_PERIOD(RESET_PERIOD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .irq_vec   (irq_vec),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model state, one entry per channel
   logic [31:0] m_cnt  [NUM_CH];
   logic [31:0] m_per  [NUM_CH];
   logic [31:0] m_snap [NUM_CH];
   logic [15:0] m_psc  [NUM_CH];
   logic [15:0] m_pc   [NUM_CH];
   bit          m_run  [NUM_CH];
   bit          m_to   [NUM_CH];
   bit          m_mis  [NUM_CH];
   bit          m_cont [NUM_CH];
   bit          m_ito  [NUM_CH];
   bit          m_ld   [NUM_CH];
   logic [31:0] m_rd;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input int unsigned ch, input int unsigned r);
      if (ch >= NUM_CH) return 32'd0;
      case (r)
         0: return {29'd0, m_mis[ch], m_run[ch], m_to[ch]};
         1: return {30'd0, m_cont[ch], m_ito[ch]};
         2: return m_per[ch];
         3: return m_snap[ch];
         4: return {16'd0, m_psc[ch]};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [NUM_CH-1:0] exp_irqv();
      logic [NUM_CH-1:0] v;
      v = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) v[c] = m_to[c] & m_ito[c];
      return v;
   endfunction

   // Advance the model by one clock using the inputs present at this edge
   task automatic model_step();
      int unsigned ach, areg;
      bit          wr, hit, tmo, clr;
      logic [31:0] cnt0;
      ach  = 32'(address[4:3]);
      areg = 32'(address[2:0]);
      wr   = chipselect && !write_n && (ach < NUM_CH) && (areg <= 4);
      if (reset) begin
         m_rd = 32'd0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = RESET_PERIOD;  m_per[c] = RESET_PERIOD;
            m_snap[c] = 32'd0;        m_psc[c] = 16'd0;  m_pc[c] = 16'd0;
            m_run[c] = 0; m_to[c] = 0; m_mis[c] = 0;
            m_cont[c] = 0; m_ito[c] = 0; m_ld[c] = 0;
         end
         return;
      end
      m_rd = m_read(ach, areg);
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         hit  = wr && (ach == c);
         tmo  = 0;
         cnt0 = m_cnt[c];
         if (m_ld[c]) begin
            m_cnt[c] = m_per[c];
            m_pc[c]  = m_psc[c];
            m_run[c] = 0;
         end else begin
            if (m_run[c]) begin
               if (m_pc[c] != 16'd0) begin
                  m_pc[c] = m_pc[c] - 16'd1;
               end else begin
                  m_pc[c] = m_psc[c];
                  if (cnt0 == 32'd0) begin
                     m_cnt[c] = m_per[c];
                     tmo = 1;
                     m_run[c] = m_cont[c];
                  end else begin
                     m_cnt[c] = cnt0 - 32'd1;
                  end
               end
            end
            if (hit && areg == 1) begin
               if (writedata[2])      m_run[c] = 1;
               else if (writedata[3]) m_run[c] = 0;
            end
         end
         m_ld[c]  = hit && (areg == 2 || areg == 4);
         clr      = hit && (areg == 0);
         m_mis[c] = !clr && (m_mis[c] || (tmo && m_to[c]));
         m_to[c]  = tmo || (m_to[c] && !clr);
         if (hit) begin
            case (areg)
               1: begin m_cont[c] = writedata[1]; m_ito[c] = writedata[0]; end
               2: m_per[c]  = writedata;
               3: m_snap[c] = cnt0;
               4: m_psc[c]  = writedata[15:0];
               default: ;
            endcase
         end
      end
   endtask

   task automatic tick();
      logic [NUM_CH-1:0] ev;
      @(posedge clk);
      model_step();
      @(negedge clk);
      ev = exp_irqv();
      check_val("readdata", readdata, m_rd);
      check_val("irq_vec", 32'(irq_vec), 32'(ev));
      check_val("irq", 32'(irq), 32'(ev != '0));
   endtask

   task automatic bus_wr(input int unsigned ch, input int unsigned r, input logic [31:0] d);
      address    = {2'(ch), 3'(r)};
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_rd(input int unsigned ch, input int unsigned r, output logic [31:0] d);
      address    = {2'(ch), 3'(r)};
      chipselect = 1'b1;
      write_n    = 1'b1;
      tick();
      d          = readdata;
      chipselect = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) tick();
   endtask

   task automatic wait_irq(input int unsigned limit, output int unsigned n);
      n = 0;
      while (irq !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
   endtask

   initial begin
      logic [31:0] d;
      int unsigned n;
      int unsigned op;

      reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      idle(2);
      reset = 1'b0;
      check_val("rst_readdata", readdata, 32'd0);
      check_val("rst_irq", 32'(irq), 32'd0);
      bus_rd(0, 2, d);
      check_val("rst_period", d, RESET_PERIOD);

      // ch0: continuous, period 4, interrupt enabled
      bus_wr(0, 2, 32'd4);
      bus_wr(0, 4, 32'd0);
      idle(1);
      bus_wr(0, 1, 32'h7);
      wait_irq(50, n);
      check_val("ch0_first_to", n, 32'd5);
      check_val("ch0_irqv", 32'(irq_vec), 32'h1);
      bus_wr(0, 0, 32'd0);
      check_val("ch0_clr_irq", 32'(irq), 32'd0);
      wait_irq(50, n);
      check_val("ch0_next_to", n, 32'd4);
      bus_wr(0, 1, 32'h8);
      bus_wr(0, 0, 32'd0);

      // ch1: one-shot, period 2, prescale 3
      bus_wr(1, 2, 32'd2);
      bus_wr(1, 4, 32'd3);
      idle(1);
      bus_wr(1, 1, 32'h4);
      address = {2'd1, 3'd0};
      idle(12);
      check_val("ch1_before_to", readdata, 32'h2);
      idle(1);
      check_val("ch1_after_to", readdata, 32'h1);
      bus_wr(1, 3, 32'd0);
      bus_rd(1, 3, d);
      check_val("ch1_reload", d, 32'd2);

      // ch2: continuous period 1, missed timeout, clear coincident with timeout
      bus_wr(2, 2, 32'd1);
      idle(1);
      bus_wr(2, 1, 32'h6);
      address = {2'd2, 3'd0};
      idle(5);
      check_val("ch2_missed", readdata, 32'h7);
      bus_wr(2, 0, 32'd0);
      bus_rd(2, 0, d);
      check_val("ch2_clr_vs_to", d, 32'h3);
      bus_wr(2, 1, 32'h8);
      bus_wr(2, 0, 32'd0);

      // ch3: period rewrite mid-count forces reload and stop
      bus_wr(3, 2, 32'd1000);
      idle(1);
      bus_wr(3, 1, 32'h4);
      idle(5);
      bus_wr(3, 2, 32'd100);
      idle(1);
      bus_wr(3, 3, 32'd0);
      bus_rd(3, 3, d);
      check_val("ch3_snap", d, 32'd100);
      bus_rd(3, 0, d);
      check_val("ch3_stopped", d, 32'h0);
      bus_wr(3, 1, 32'hC);
      bus_rd(3, 0, d);
      check_val("ch3_start_wins", d, 32'h2);
      bus_wr(3, 5, 32'hFFFF_FFFF);
      bus_wr(3, 6, 32'hFFFF_FFFF);
      bus_wr(3, 7, 32'hFFFF_FFFF);
      bus_rd(3, 6, d);
      check_val("unmapped_rd", d, 32'd0);
      bus_rd(3, 2, d);
      check_val("unmapped_wr_period", d, 32'd100);
      bus_rd(3, 4, d);
      check_val("unmapped_wr_psc", d, 32'd0);

      // Reset mid-count with irq pending
      bus_wr(0, 2, 32'd4);
      idle(1);
      bus_wr(0, 1, 32'h7);
      bus_wr(1, 1, 32'h6);
      bus_wr(2, 1, 32'h6);
      wait_irq(50, n);
      check_val("pre_rst_irq", 32'(irq), 32'd1);
      address = {2'd0, 3'd2};
      idle(1);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      check_val("mid_rst_irq", 32'(irq), 32'd0);
      check_val("mid_rst_readdata", readdata, 32'd0);
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         bus_wr(c, 3, 32'd0);
         bus_rd(c, 3, d);
         check_val("rst_counter", d, RESET_PERIOD);
      end

      // Randomised traffic, every cycle compared against the model
      for (int i = 0; i < 4000; i++) begin
         op         = $urandom_range(0, 99);
         address    = 5'($urandom);
         chipselect = 1'($urandom_range(0, 1));
         write_n    = 1'b1;
         writedata  = $urandom;
         reset      = (op == 99) && ($urandom_range(0, 3) == 0);
         if (op < 30) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
            if (address[2:0] == 3'd2 && $urandom_range(0, 7) != 0)
               writedata = 32'($urandom_range(0, 9));
            else if (address[2:0] == 3'd4)
               writedata = {16'($urandom), 16'($urandom_range(0, 3))};
         end
         tick();
      end
      reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
